// File: rtl/dram_buffer_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : dram_buffer_sched_if
// Description : Bundles the requester handshakes, the dram_buffer FIFO
//               control/status and the DRAM write-beat handshake used by
//               dram_buffer_sched.
//   master : scheduler view (drives ready/FIFO control/DRAM beat/status)
//   slave  : environment view (requesters, FIFO and DRAM engine)
//   Signals: en, req{0,1}_{valid,data,ready}, fifo_{wr_en,datain,full,
//            rd_en,dataout,empty}, dram_wr_{valid,data,ready},
//            last_grant, beats_sent
// Revision    : 1.0 - initial release
// ============================================================================
interface dram_buffer_sched_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic              en;
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              fifo_wr_en;
  logic [DATA_W-1:0] fifo_datain;
  logic              fifo_full;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_dataout;
  logic              fifo_empty;
  logic              dram_wr_valid;
  logic [DATA_W-1:0] dram_wr_data;
  logic              dram_wr_ready;
  logic              last_grant;
  logic [CNT_W-1:0]  beats_sent;

  modport master (
    input  en,
    input  req0_valid, req0_data,
    output req0_ready,
    input  req1_valid, req1_data,
    output req1_ready,
    output fifo_wr_en, fifo_datain,
    input  fifo_full,
    output fifo_rd_en,
    input  fifo_dataout, fifo_empty,
    output dram_wr_valid, dram_wr_data,
    input  dram_wr_ready,
    output last_grant, beats_sent
  );

  modport slave (
    output en,
    output req0_valid, req0_data,
    input  req0_ready,
    output req1_valid, req1_data,
    input  req1_ready,
    input  fifo_wr_en, fifo_datain,
    output fifo_full,
    input  fifo_rd_en,
    output fifo_dataout, fifo_empty,
    input  dram_wr_valid, dram_wr_data,
    output dram_wr_ready,
    input  last_grant, beats_sent
  );
endinterface
`default_nettype wire

// File: rtl/dram_buffer_sched.sv
`default_nettype none
// ============================================================================
// Module      : dram_buffer_sched
// Description : Shares the dram_buffer FIFO between two write requesters with
//               per-beat round-robin arbitration (zero-latency push path) and
//               drains it toward the DRAM write datapath through an
//               IDLE -> LOAD -> SEND FSM with a valid/ready handshake.
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : dram_buffer_sched_if.master (requesters, FIFO, DRAM beat, status)
// Revision    : 1.0 - initial release
// ============================================================================
module dram_buffer_sched #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  dram_buffer_sched_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_last_grant;
  logic              r_wr_valid;
  logic [DATA_W-1:0] r_wr_data;
  logic [CNT_W-1:0]  r_beats_sent;

  logic              w_eligible;
  logic              w_winner;
  logic              w_push;
  logic              w_pop;
  logic              w_load;
  logic              w_handshake;

  // --------------------------------------------------------------------------
  // Arbitration and write path
  // --------------------------------------------------------------------------
  // rst is folded into eligibility so the readies and the push strobe are
  // held low for the whole reset window, not just after the first edge.
  assign w_eligible = bus.en & ~bus.fifo_full & ~rst;

  // A lone valid requester wins outright; with both (or neither) valid the
  // requester that was not granted last gets the slot.
  always_comb begin
    w_winner = ~r_last_grant;
    if (bus.req0_valid && !bus.req1_valid) begin
      w_winner = 1'b0;
    end else if (bus.req1_valid && !bus.req0_valid) begin
      w_winner = 1'b1;
    end
  end

  assign w_push          = w_eligible & (w_winner ? bus.req1_valid : bus.req0_valid);
  assign bus.req0_ready  = w_eligible & ~w_winner;
  assign bus.req1_ready  = w_eligible &  w_winner;
  assign bus.fifo_wr_en  = w_push;
  assign bus.fifo_datain = w_winner ? bus.req1_data : bus.req0_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b0;
    end else if (w_push) begin
      r_last_grant <= w_winner;
    end
  end

  // --------------------------------------------------------------------------
  // Drain FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The pop strobe is a pure decode of IDLE; the FIFO presents dataout one
  // cycle later, which is exactly the LOAD cycle that captures it.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_handshake = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.en && !bus.fifo_empty && !rst) begin
          w_pop       = 1'b1;
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = SEND;
      end
      SEND: begin
        // en is deliberately not consulted: an in-flight beat always finishes.
        if (r_wr_valid && bus.dram_wr_ready) begin
          w_handshake = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.fifo_rd_en = w_pop;

  // --------------------------------------------------------------------------
  // DRAM beat register and delivered-beat counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_valid   <= 1'b0;
      r_wr_data    <= '0;
      r_beats_sent <= '0;
    end else if (w_load) begin
      r_wr_valid <= 1'b1;
      r_wr_data  <= bus.fifo_dataout;
    end else if (w_handshake) begin
      r_wr_valid   <= 1'b0;
      // Free-running wrap is intended; no overflow indication.
      r_beats_sent <= r_beats_sent + 1'b1;
    end
  end

  assign bus.dram_wr_valid = r_wr_valid;
  assign bus.dram_wr_data  = r_wr_data;
  assign bus.last_grant    = r_last_grant;
  assign bus.beats_sent    = r_beats_sent;

endmodule
`default_nettype wire

// File: tb/tb_dram_buffer_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_dram_buffer_sched
// Description : Directed bench for dram_buffer_sched with a 16-deep FIFO
//               model (forcible full/empty flags) and a DRAM beat monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_buffer_sched;

  localparam int C_DW    = 8;
  localparam int C_CW    = 16;
  localparam int C_DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dram_buffer_sched_if #(.DATA_W(C_DW), .CNT_W(C_CW)) bus ();

  dram_buffer_sched #(.DATA_W(C_DW), .CNT_W(C_CW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // FIFO model
  logic [C_DW-1:0] r_mem [0:C_DEPTH-1];
  int              r_wp, r_rp, r_cnt;
  logic            force_full  = 1'b0;
  logic            force_empty = 1'b0;

  assign bus.fifo_full  = (r_cnt == C_DEPTH) | force_full;
  assign bus.fifo_empty = (r_cnt == 0) | force_empty;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp             <= 0;
      r_rp             <= 0;
      r_cnt            <= 0;
      bus.fifo_dataout <= '0;
    end else begin
      if (bus.fifo_wr_en) begin
        r_mem[r_wp] <= bus.fifo_datain;
        r_wp        <= (r_wp + 1) % C_DEPTH;
      end
      if (bus.fifo_rd_en) begin
        bus.fifo_dataout <= r_mem[r_rp];
        r_rp             <= (r_rp + 1) % C_DEPTH;
      end
      r_cnt <= r_cnt + (bus.fifo_wr_en ? 1 : 0) - (bus.fifo_rd_en ? 1 : 0);
    end
  end

  // Logs of FIFO writes and delivered DRAM beats
  logic [C_DW-1:0] wr_q   [$];
  logic [C_DW-1:0] sent_q [$];

  always @(posedge clk) begin
    if (!rst && bus.fifo_wr_en) wr_q.push_back(bus.fifo_datain);
    if (!rst && bus.dram_wr_valid && bus.dram_wr_ready) sent_q.push_back(bus.dram_wr_data);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int max);
    int k = 0;
    while (bus.dram_wr_valid !== 1'b1 && k < max) begin
      @(negedge clk);
      k++;
    end
    if (k >= max) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_beats(input string tag, input int n, input int max);
    int k = 0;
    while (int'(bus.beats_sent) != n && k < max) begin
      @(negedge clk);
      k++;
    end
    if (k >= max) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic push0(input logic [C_DW-1:0] d);
    bus.req0_valid = 1'b1;
    bus.req0_data  = d;
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [C_DW-1:0] exp_wr [4];
    int a, b, n_rd, n_wr, n_vl;

    bus.en            = 1'b1;
    bus.req0_valid    = 1'b1;
    bus.req0_data     = 8'h11;
    bus.req1_valid    = 1'b1;
    bus.req1_data     = 8'h22;
    bus.dram_wr_ready = 1'b1;

    // ---- Reset state (inputs active, outputs must still be low) ----
    repeat (2) @(negedge clk);
    chk("rst_req0_ready", bus.req0_ready, 0);
    chk("rst_req1_ready", bus.req1_ready, 0);
    chk("rst_fifo_wr_en", bus.fifo_wr_en, 0);
    chk("rst_fifo_rd_en", bus.fifo_rd_en, 0);
    chk("rst_dram_valid", bus.dram_wr_valid, 0);
    chk("rst_dram_data",  bus.dram_wr_data, 0);
    chk("rst_beats_sent", bus.beats_sent, 0);
    chk("rst_last_grant", bus.last_grant, 0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // ---- Single requester streaming 0x00..0x04 ----
    @(posedge clk); #1;
    for (int n = 0; n < 5; n++) begin
      bus.req0_valid = 1'b1;
      bus.req0_data  = 8'(n);
      @(negedge clk);
      chk($sformatf("t1_req0_ready_%0d", n), bus.req0_ready, 1);
      @(posedge clk); #1;
    end
    bus.req0_valid = 1'b0;
    wait_beats("t1_drain", 5, 40);
    chk("t1_beats_sent", bus.beats_sent, 5);
    chk("t1_sent_cnt", sent_q.size(), 5);
    for (int n = 0; n < 5 && n < sent_q.size(); n++)
      chk($sformatf("t1_sent_%0d", n), sent_q[n], n);

    // ---- Both valid: alternate B0,A0,B1,A1 ----
    @(posedge clk); #1;
    wr_q.delete();
    a = 0;
    b = 0;
    for (int k = 0; k < 4; k++) begin
      bus.req0_valid = 1'b1;
      bus.req0_data  = 8'(8'hA0 + a);
      bus.req1_valid = 1'b1;
      bus.req1_data  = 8'(8'hB0 + b);
      @(negedge clk);
      chk($sformatf("t2_last_grant_%0d", k), bus.last_grant, k % 2);
      chk($sformatf("t2_req1_ready_%0d", k), bus.req1_ready, (k % 2 == 0) ? 1 : 0);
      if (bus.req0_ready) a++;
      if (bus.req1_ready) b++;
      @(posedge clk); #1;
    end
    chk("t2_last_grant_end", bus.last_grant, 0);

    // ---- FIFO full held for 4 cycles with both valid ----
    force_full = 1'b1;
    bus.req0_data = 8'hA2;
    bus.req1_data = 8'hB2;
    n_wr = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready || bus.fifo_wr_en) n_wr++;
      @(posedge clk); #1;
    end
    chk("t3_blocked_cycles_active", n_wr, 0);
    chk("t3_wr_log_while_full", wr_q.size(), 4);
    force_full = 1'b0;
    @(negedge clk);
    chk("t3_release_req1_ready", bus.req1_ready, 1);
    chk("t3_release_req0_ready", bus.req0_ready, 0);
    chk("t3_release_datain", bus.fifo_datain, 8'hB2);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    exp_wr = '{8'hB0, 8'hA0, 8'hB1, 8'hA1};
    chk("t3_wr_cnt", wr_q.size(), 5);
    for (int k = 0; k < 4 && k < wr_q.size(); k++)
      chk($sformatf("t2_wr_%0d", k), wr_q[k], exp_wr[k]);
    if (wr_q.size() >= 5) chk("t3_wr_last", wr_q[4], 8'hB2);
    wait_beats("t3_drain", 10, 60);
    chk("t3_beats_sent", bus.beats_sent, 10);
    if (sent_q.size() >= 10) begin
      chk("t3_sent_5", sent_q[5], 8'hB0);
      chk("t3_sent_8", sent_q[8], 8'hA1);
      chk("t3_sent_9", sent_q[9], 8'hB2);
    end else begin
      chk("t3_sent_cnt", sent_q.size(), 10);
    end

    // ---- DRAM back-pressure for 6 cycles ----
    @(posedge clk); #1;
    bus.dram_wr_ready = 1'b0;
    push0(8'h5A);
    push0(8'h5B);
    wait_valid("t4_valid", 20);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t4_valid_%0d", k), bus.dram_wr_valid, 1);
      chk($sformatf("t4_data_%0d", k), bus.dram_wr_data, 8'h5A);
      chk($sformatf("t4_rd_en_%0d", k), bus.fifo_rd_en, 0);
      chk($sformatf("t4_beats_%0d", k), bus.beats_sent, 10);
      @(negedge clk);
    end
    bus.dram_wr_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_beats_after_pulse", bus.beats_sent, 11);
    chk("t4_valid_after_pulse", bus.dram_wr_valid, 0);
    wait_beats("t4_drain", 12, 20);
    chk("t4_beats_final", bus.beats_sent, 12);
    if (sent_q.size() >= 12) chk("t4_sent_11", sent_q[11], 8'h5B);

    // ---- Empty flag forced: no pops ----
    @(posedge clk); #1;
    force_empty = 1'b1;
    n_rd = 0;
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'h66;
    @(negedge clk);
    if (bus.fifo_rd_en) n_rd++;
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.fifo_rd_en) n_rd++;
    end
    chk("t5_rd_en_while_empty", n_rd, 0);
    chk("t5_beats_while_empty", bus.beats_sent, 12);
    force_empty = 1'b0;
    wait_beats("t5_drain", 13, 20);
    if (sent_q.size() >= 13) chk("t5_sent_12", sent_q[12], 8'h66);

    // ---- en dropped during SEND ----
    @(posedge clk); #1;
    bus.dram_wr_ready = 1'b0;
    push0(8'h77);
    push0(8'h78);
    wait_valid("t5_valid", 20);
    @(posedge clk); #1;
    bus.en         = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'h79;
    @(negedge clk);
    chk("t5_en0_req0_ready", bus.req0_ready, 0);
    chk("t5_en0_wr_en", bus.fifo_wr_en, 0);
    chk("t5_en0_valid_held", bus.dram_wr_valid, 1);
    bus.dram_wr_ready = 1'b1;
    @(posedge clk); #1;
    chk("t5_en0_beats", bus.beats_sent, 14);
    n_rd = 0;
    n_wr = 0;
    n_vl = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.fifo_rd_en) n_rd++;
      if (bus.fifo_wr_en) n_wr++;
      if (bus.dram_wr_valid) n_vl++;
    end
    chk("t5_en0_rd_cycles", n_rd, 0);
    chk("t5_en0_wr_cycles", n_wr, 0);
    chk("t5_en0_valid_cycles", n_vl, 0);
    chk("t5_en0_beats_hold", bus.beats_sent, 14);
    if (sent_q.size() >= 14) chk("t5_sent_13", sent_q[13], 8'h77);
    bus.req0_valid = 1'b0;

    // ---- Reset asserted in SEND ----
    @(posedge clk); #1;
    bus.dram_wr_ready = 1'b0;
    bus.en = 1'b1;
    wait_valid("t6_valid", 20);
    chk("t6_pre_data", bus.dram_wr_data, 8'h78);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", bus.dram_wr_valid, 0);
    chk("t6_rst_beats", bus.beats_sent, 0);
    chk("t6_rst_data", bus.dram_wr_data, 0);
    chk("t6_rst_last_grant", bus.last_grant, 0);
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'hC0;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 8'hD0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_req1_ready", bus.req1_ready, 1);
    chk("t6_req0_ready", bus.req0_ready, 0);
    chk("t6_datain", bus.fifo_datain, 8'hD0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("t6_last_grant", bus.last_grant, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dram_buffer_sched.md
Name: dram_buffer_sched

Overview:
- Schedules the shared 8-bit `dram_buffer` FIFO between two write requesters using per-beat round-robin arbitration.
- Drains the FIFO toward the DRAM write datapath with a 3-state pop/load/send FSM and valid/ready handshake.
- Sits between the host-side requesters and the DRAM command/data engine.
- Owns all `wr_en`/`rd_en` sequencing of `dram_buffer`.

Parameters:
- DATA_W, 8, data width of requesters, FIFO and DRAM write data.
- CNT_W, 16, width of the delivered-beat counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global enable; 0 blocks new accepts and new pops; an in-flight send completes.
- req0_valid  in  1  requester 0 has a beat.
- req0_data  in  DATA_W  requester 0 beat.
- req0_ready  out  1  requester 0 beat accepted this cycle when valid & ready.
- req1_valid  in  1  requester 1 has a beat.
- req1_data  in  DATA_W  requester 1 beat.
- req1_ready  out  1  requester 1 beat accepted this cycle when valid & ready.
- fifo_wr_en  out  1  to `dram_buffer` `wr_en`.
- fifo_datain  out  DATA_W  to `dram_buffer` `datain`.
- fifo_full  in  1  from `dram_buffer` `full_flag`.
- fifo_rd_en  out  1  to `dram_buffer` `rd_en`.
- fifo_dataout  in  DATA_W  from `dram_buffer` `dataout`; valid the cycle after `fifo_rd_en`.
- fifo_empty  in  1  from `dram_buffer` `empty_flag`.
- dram_wr_valid  out  1  write beat presented to DRAM engine.
- dram_wr_data  out  DATA_W  write beat.
- dram_wr_ready  in  1  DRAM engine accepts the beat when valid & ready.
- last_grant  out  1  id of the requester most recently accepted.
- beats_sent  out  CNT_W  count of beats delivered to DRAM; wraps at 2^CNT_W.

Behaviour:
- Reset (async, rst=1), all outputs held at 0:
  - `req*_ready`, `fifo_wr_en`, `fifo_rd_en`, `dram_wr_valid`, `dram_wr_data`, `beats_sent`, `last_grant` = 0.
  - FSM = IDLE.
  - Because `last_grant`=0, requester 1 has priority on the first contested cycle.
- Arbitration (combinational):
  - `eligible` = en & !fifo_full.
  - Only one valid requester: it wins.
  - Both valid: the requester != `last_grant` wins.
  - `reqX_ready` = eligible & (winner==X). At most one ready per cycle.
- Write path (combinational):
  - `fifo_wr_en` = eligible & winner's valid.
  - `fifo_datain` = winner's data.
  - Zero added latency.
  - `last_grant` <= winner on each accepted beat.
- Full boundary: `fifo_full`=1 forces both readies and `fifo_wr_en` to 0. Requesters must hold their data. No beat is lost or duplicated.
- Drain FSM:
  - IDLE: if en & !fifo_empty, then `fifo_rd_en`=1 for exactly this cycle and go to LOAD; else stay. `fifo_rd_en` is a combinational decode of IDLE; it is never asserted while `fifo_empty`=1.
  - LOAD: `dram_wr_data` <= `fifo_dataout`, `dram_wr_valid` <= 1, go to SEND.
  - SEND: hold `dram_wr_valid` and data stable until `dram_wr_ready`. On the handshake: `dram_wr_valid` <= 0, `beats_sent` += 1, go to IDLE.
- Throughput: at most one beat per 3 cycles. Minimum latency from FIFO non-empty to `dram_wr_valid` = 2 cycles.
- Simultaneous push and pop in the same cycle is legal; the FIFO handles both.
- `en` deasserted mid-operation: LOAD/SEND complete normally; the FSM then parks in IDLE and no new push occurs.
- `dram_wr_ready` asserted while `dram_wr_valid`=0 is ignored.
- `beats_sent` wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-SEND: the beat is discarded and `dram_wr_valid` drops immediately (asynchronous). FIFO contents are the FIFO's own reset responsibility.

Test Plan:
- After reset with req0_valid=1 data=0x00..0x04 over 5 cycles, req1 idle, `dram_wr_ready`=1: req0_ready=1 each cycle; DRAM sees 0x00,0x01,0x02,0x03,0x04 in order; beats_sent=5.
- Both valid every cycle (req0 0xA0+n, req1 0xB0+n): FIFO writes alternate B0,A0,B1,A1; last_grant toggles each accept.
- Hold fifo_full=1 for 4 cycles with both valid: req0_ready=req1_ready=fifo_wr_en=0 throughout. On release, the winning requester's beat is written once.
- `dram_wr_ready`=0 for 6 cycles in SEND: dram_wr_valid stays 1 with stable data; fifo_rd_en=0; beats_sent unchanged. Ready pulse then gives beats_sent+1.
- fifo_empty=1 with en=1: fifo_rd_en never asserts. Also en=0 during SEND: the beat completes, then no further pops or pushes.
- Assert rst in SEND: dram_wr_valid=0 and beats_sent=0 in the same cycle; after release the arbiter gives requester 1 priority.
